credit_dispatch_tx: RTL and testbench
=====================================

// Module: credit_dispatch_tx
// PURPOSE
//  Transmit-side counterpart of the per-channel arbitrated FIFO bank. Accepts one tagged
//  stream (valid/ready) and steers each word into the push[]/data port of channel in_tag.
//  Holds one credit per free downstream FIFO slot, so no push ever hits a full FIFO.
//  Credits return on the downstream pop/grant (credit_ret[i]).
//  Sits between the upstream producer and the NUM_FIFOS FIFO bank.
// PARAMETERS
//  NUM_FIFOS    4                   number of destination channels
//  WIDTH        8                   data width
//  DEPTH        4                   credits per channel at reset (= downstream FIFO depth)
//  TAGWIDTH     $clog2(NUM_FIFOS)   destination tag width
//  CNTW         $clog2(DEPTH+1)     credit counter width
// PORTS
//  clk            in   1                  clock
//  rst            in   1                  one clock; reset is synchronous and active-low
//  in_vld         in   1                  upstream word valid
//  in_tag         in   TAGWIDTH           destination channel
//  in_data        in   WIDTH              upstream data
//  in_rdy         out  1                  upstream may transfer (in_vld & in_rdy)
//  push           out  NUM_FIFOS          one-hot push to destination FIFO, at most 1 bit set
//  flat_data_out  out  NUM_FIFOS*WIDTH    per-channel data; only the pushed slice is defined
//  credit_ret     in   NUM_FIFOS          per-channel pop; returns one credit
//  has_credits    out  NUM_FIFOS          credit count of channel i is non-zero
//  cr_err         out  1                  sticky: credit returned while counter already at DEPTH
//  tag_err        out  1                  sticky: accepted word with in_tag >= NUM_FIFOS
//  stall_cnt      out  16                 see CONFIGURATION
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge):
//    - hold_vld=0, all credit counters=DEPTH, cr_err=0, tag_err=0, stall_cnt=0.
//    - Outputs: push=0, in_rdy=1, has_credits=all ones.
//    - Reset mid-transfer discards the held word and restores all credits.
//  - Holding register (hold_vld, hold_tag, hold_data), one entry:
//    - fire = hold_vld & has_credits[hold_tag].
//    - push[i] = fire & (hold_tag==i), purely from registers; no in_* -> push comb path.
//    - in_rdy = !hold_vld | fire. This gives full throughput when credits are available.
//    - Accept (in_vld & in_rdy): hold <= {1,in_tag,in_data}. Otherwise, if fire, hold_vld <= 0.
//    - Latency: accepted word pushes 1 cycle later at the earliest. It waits in hold until a credit appears.
//    - Head-of-line: a blocked word stalls all channels. This is intended; no reordering.
//  - Every slice of flat_data_out carries hold_data. Downstream qualifies the slice by push.
//  - Credit counter per channel, width CNTW:
//    - push only: -1.
//    - credit_ret only: +1.
//    - Both in the same cycle: unchanged.
//    - credit_ret at DEPTH without push: counter stays DEPTH, cr_err <= 1.
//    - A push at count 0 is impossible by construction.
//  - Bad tag: a word accepted with in_tag >= NUM_FIFOS sets tag_err and is dropped on entry (hold_vld stays 0).
//    in_rdy is unaffected.
//  - Invariant: credits[i] + words in downstream FIFO i == DEPTH.
// CONFIGURATION
//  DISPATCH_STALL_CNT_EN
//   defined: stall_cnt is a 16-bit counter, +1 each cycle where hold_vld & !fire.
//            It saturates at 16'hFFFF and clears only on reset.
//   undefined: stall_cnt tied to 16'd0; no counter flops are built.
// STRUCTURE
//  Shared package/header:
//   - TAGWIDTH/CNTW derivations.
//   - Default NUM_FIFOS/WIDTH/DEPTH macros, reused with the FIFO bank top.
//  Sub-module tx_credit_tracker: one channel's counter, saturation and error flag.
//   - Ports: clk, rst, take, give, has_credits, err.
//   - Instantiated NUM_FIFOS times in a generate loop; top-level cr_err = sticky OR of err.
//  Formal section (under FORMAL):
//   - assert $onehot0(push).
//   - assert push[i] -> has_credits[i].
//   - assert counter <= DEPTH.
// TESTING (NUM_FIFOS=4, DEPTH=2, WIDTH=8)
//  T1 reset: hold rst=0 for 2 cycles, then release
//     -> push=0, in_rdy=1, has_credits=4'hF, errs=0.
//  T2 throughput: words tag 0,1,2,3 back-to-back, no returns
//     -> push 0001,0010,0100,1000 on cycles 1-4; data matches; in_rdy stays 1.
//  T3 exhaustion: 3 words to tag 2 with no credit_ret
//     -> 2 pushes, then has_credits[2]=0 and in_rdy=0.
//     -> credit_ret[2] pulse: third word pushes the next cycle.
//  T4 simultaneous: push to ch1 in the same cycle as credit_ret[1]
//     -> count unchanged; cr_err=0.
//  T5 errors: credit_ret[0] with count=2 -> cr_err=1 sticky.
//     in_tag=3 with NUM_FIFOS=3 build -> tag_err=1 and no push.
//  T6 reset mid-stall: word held with 0 credits, assert rst
//     -> hold cleared, credits=2, no push.
//     -> with DISPATCH_STALL_CNT_EN: stall_cnt counts stalled cycles, then 0 after reset.

Source files
------------

// File: rtl/credit_dispatch_tx_pkg.sv
// Shared definitions for the credit-based transmit dispatcher.
// Holds the default channel count, width and depth macros (also used by the FIFO bank top),
// the derived tag and credit-counter width helpers, and the credit-update opcode.
// No ports (package).

`ifndef CDT_NUM_FIFOS
`define CDT_NUM_FIFOS 4
`endif
`ifndef CDT_WIDTH
`define CDT_WIDTH 8
`endif
`ifndef CDT_DEPTH
`define CDT_DEPTH 4
`endif

package credit_dispatch_tx_pkg;

   localparam int unsigned DEF_NUM_FIFOS = `CDT_NUM_FIFOS;
   localparam int unsigned DEF_WIDTH     = `CDT_WIDTH;
   localparam int unsigned DEF_DEPTH     = `CDT_DEPTH;
   localparam int unsigned STALL_W       = 16;

   // Destination tag width; a single channel still needs one tag bit.
   function automatic int unsigned tag_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Credit counter width, able to hold 0..depth.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Per-cycle credit update, encoded as {take, give}.
   typedef enum logic [1:0] {
      CR_IDLE = 2'b00,
      CR_GIVE = 2'b01,
      CR_TAKE = 2'b10,
      CR_BOTH = 2'b11
   } cr_op_e;

endpackage

// File: rtl/credit_dispatch_tx_if.sv
// Stream and FIFO-bank bundle for the credit dispatcher.
//   in_vld/in_tag/in_data/in_rdy : tagged upstream valid/ready stream
//   push/flat_data_out           : one-hot push and per-channel data to the FIFO bank
//   credit_ret                   : per-channel pop from the FIFO bank, returns a credit
// master = producer/FIFO-bank side, slave = dispatcher side.

interface credit_dispatch_tx_if
   import credit_dispatch_tx_pkg::*;
#(
   parameter int unsigned NUM_FIFOS = DEF_NUM_FIFOS,
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned TAGWIDTH  = tag_w(NUM_FIFOS)
);

   logic                       in_vld;
   logic [TAGWIDTH-1:0]        in_tag;
   logic [WIDTH-1:0]           in_data;
   logic                       in_rdy;
   logic [NUM_FIFOS-1:0]       push;
   logic [NUM_FIFOS*WIDTH-1:0] flat_data_out;
   logic [NUM_FIFOS-1:0]       credit_ret;

   modport master (
      output in_vld, in_tag, in_data, credit_ret,
      input  in_rdy, push, flat_data_out
   );

   modport slave (
      input  in_vld, in_tag, in_data, credit_ret,
      output in_rdy, push, flat_data_out
   );

endinterface

// File: rtl/credit_dispatch_tx_tracker.sv
// One channel's credit counter.
//   clk, rst    : clock, synchronous active-low reset
//   take        : a word is pushed to this channel (consumes a credit)
//   give        : downstream popped a word (returns a credit)
//   has_credits : counter is non-zero (registered)
//   err         : sticky, a credit came back while the counter was already full

module tx_credit_tracker
   import credit_dispatch_tx_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned CNTW  = cnt_w(DEPTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic take,
   input  logic give,
   output logic has_credits,
   output logic err
);

   logic [CNTW-1:0] cnt;
   logic [CNTW-1:0] cnt_nxt;
   logic            err_nxt;
   cr_op_e          op;

   assign op = cr_op_e'({take, give});

   // Next count; a simultaneous take and give cancel out.
   always_comb begin
      cnt_nxt = cnt;
      err_nxt = err;
      case (op)
         CR_TAKE: cnt_nxt = cnt - CNTW'(1);
         CR_GIVE: begin
            if (cnt == CNTW'(DEPTH)) err_nxt = 1'b1;
            else                     cnt_nxt = cnt + CNTW'(1);
         end
         default: ;
      endcase
   end

   // has_credits is registered from the next count so it lines up with cnt.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt         <= CNTW'(DEPTH);
         has_credits <= 1'b1;
         err         <= 1'b0;
      end else begin
         cnt         <= cnt_nxt;
         has_credits <= (cnt_nxt != '0);
         err         <= err_nxt;
      end
   end

`ifdef FORMAL
   ap_cnt_bound: assert property (@(posedge clk) disable iff (!rst) cnt <= CNTW'(DEPTH));
`endif

endmodule

// File: rtl/credit_dispatch_tx.sv
// Credit-based transmit dispatcher: steers a tagged valid/ready stream into a bank of
// NUM_FIFOS downstream FIFOs, holding one credit per free FIFO slot so no push hits a full FIFO.
//   clk, rst    : clock, synchronous active-low reset
//   bus (slave) : upstream stream, one-hot push + flat per-channel data, credit_ret
//   has_credits : per-channel credit count non-zero
//   cr_err      : sticky, credit returned to a full counter
//   tag_err     : sticky, accepted word carried an out-of-range tag (word dropped)
//   stall_cnt   : saturating count of cycles a held word waited for a credit;
//                 built only when DISPATCH_STALL_CNT_EN is defined, otherwise tied to zero

module credit_dispatch_tx
   import credit_dispatch_tx_pkg::*;
#(
   parameter int unsigned NUM_FIFOS = DEF_NUM_FIFOS,
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned DEPTH     = DEF_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   credit_dispatch_tx_if.slave     bus,
   output logic [NUM_FIFOS-1:0]    has_credits,
   output logic                    cr_err,
   output logic                    tag_err,
   output logic [STALL_W-1:0]      stall_cnt
);

   localparam int unsigned TAGWIDTH = tag_w(NUM_FIFOS);
   localparam int unsigned CNTW     = cnt_w(DEPTH);

   logic                 hold_vld;
   logic [TAGWIDTH-1:0]  hold_tag;
   logic [WIDTH-1:0]     hold_data;

   logic [NUM_FIFOS-1:0] hold_sel_c;
   logic [NUM_FIFOS-1:0] in_sel_c;
   logic [NUM_FIFOS-1:0] push_c;
   logic [NUM_FIFOS-1:0] err_c;
   logic                 fire_c;
   logic                 accept_c;
   logic                 tag_ok_c;

   // Per-channel tag decode and credit tracking.
   for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_ch
      assign hold_sel_c[i] = (hold_tag == TAGWIDTH'(i));
      assign in_sel_c[i]   = (bus.in_tag == TAGWIDTH'(i));

      tx_credit_tracker #(
         .DEPTH (DEPTH),
         .CNTW  (CNTW)
      ) u_trk (
         .clk         (clk),
         .rst         (rst),
         .take        (push_c[i]),
         .give        (bus.credit_ret[i]),
         .has_credits (has_credits[i]),
         .err         (err_c[i])
      );
   end

   // Push depends only on registered state, never on the in_* inputs.
   assign push_c   = {NUM_FIFOS{hold_vld}} & hold_sel_c & has_credits;
   assign fire_c   = |push_c;
   // A tag matching no channel is out of range.
   assign tag_ok_c = |in_sel_c;
   assign accept_c = bus.in_vld & bus.in_rdy;

   assign bus.push          = push_c;
   assign bus.in_rdy        = !hold_vld | fire_c;
   assign bus.flat_data_out = {NUM_FIFOS{hold_data}};

   // Each tracker error is already sticky.
   assign cr_err = |err_c;

   // Single-entry holding register; a bad-tag word is dropped on entry.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hold_vld  <= 1'b0;
         hold_tag  <= '0;
         hold_data <= '0;
         tag_err   <= 1'b0;
      end else if (accept_c) begin
         hold_vld  <= tag_ok_c;
         hold_tag  <= bus.in_tag;
         hold_data <= bus.in_data;
         if (!tag_ok_c) tag_err <= 1'b1;
      end else if (fire_c) begin
         hold_vld  <= 1'b0;
      end
   end

`ifdef DISPATCH_STALL_CNT_EN
   // Cycles where a held word is blocked waiting for a credit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (hold_vld && !fire_c && (stall_cnt != {STALL_W{1'b1}})) begin
         stall_cnt <= stall_cnt + STALL_W'(1);
      end
   end
`else
   assign stall_cnt = '0;
`endif

`ifdef FORMAL
   ap_push_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(push_c));
   ap_push_credit: assert property (@(posedge clk) disable iff (!rst) (push_c & ~has_credits) == '0);
`endif

endmodule

// File: tb/tb_credit_dispatch_tx.sv
// Directed bench for credit_dispatch_tx: a 4-channel, depth-2 instance driven from a vector
// table, plus a 3-channel instance for out-of-range tags, and reset/stall sequences.

module tb_credit_dispatch_tx;

   localparam int unsigned NF = 4;
   localparam int unsigned W  = 8;
   localparam int unsigned D  = 2;
   localparam int unsigned NV = 24;

`ifdef DISPATCH_STALL_CNT_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic clk;
   logic rst;

   logic [NF-1:0] has0;
   logic          cr_err0, tag_err0;
   logic [15:0]   stall0;
   logic [2:0]    has1;
   logic          cr_err1, tag_err1;
   logic [15:0]   stall1;

   int checks = 0;
   int errors = 0;

   credit_dispatch_tx_if #(.NUM_FIFOS(NF), .WIDTH(W)) bus0 ();
   credit_dispatch_tx_if #(.NUM_FIFOS(3),  .WIDTH(W)) bus1 ();

   credit_dispatch_tx #(.NUM_FIFOS(NF), .WIDTH(W), .DEPTH(D)) dut0 (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus0),
      .has_credits (has0),
      .cr_err      (cr_err0),
      .tag_err     (tag_err0),
      .stall_cnt   (stall0)
   );

   credit_dispatch_tx #(.NUM_FIFOS(3), .WIDTH(W), .DEPTH(D)) dut1 (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus1),
      .has_credits (has1),
      .cr_err      (cr_err1),
      .tag_err     (tag_err1),
      .stall_cnt   (stall1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       vld;
      logic [1:0] tag;
      logic [7:0] data;
      logic [3:0] ret;
      logic [3:0] e_push;
      logic       e_rdy;
      logic [3:0] e_has;
      logic       e_cr;
      logic [7:0] e_data;
   } vec_t;

   vec_t vt [NV];

   function automatic vec_t mk(input logic vld, input logic [1:0] tag, input logic [7:0] data,
                               input logic [3:0] ret, input logic [3:0] e_push, input logic e_rdy,
                               input logic [3:0] e_has, input logic e_cr, input logic [7:0] e_data);
      vec_t v;
      v.vld = vld; v.tag = tag; v.data = data; v.ret = ret;
      v.e_push = e_push; v.e_rdy = e_rdy; v.e_has = e_has; v.e_cr = e_cr; v.e_data = e_data;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic vld, input logic [1:0] tag, input logic [7:0] data,
                         input logic [3:0] ret);
      bus0.in_vld     = vld;
      bus0.in_tag     = tag;
      bus0.in_data    = data;
      bus0.credit_ret = ret;
   endtask

   initial begin
      // Throughput, exhaustion, simultaneous take/give, credit overflow error.
      vt[0]  = mk(1, 0, 8'hA0, 4'h0, 4'h1, 1, 4'hF, 0, 8'hA0);
      vt[1]  = mk(1, 1, 8'hA1, 4'h0, 4'h2, 1, 4'hF, 0, 8'hA1);
      vt[2]  = mk(1, 2, 8'hA2, 4'h0, 4'h4, 1, 4'hF, 0, 8'hA2);
      vt[3]  = mk(1, 3, 8'hA3, 4'h0, 4'h8, 1, 4'hF, 0, 8'hA3);
      vt[4]  = mk(0, 0, 8'h00, 4'h0, 4'h0, 1, 4'hF, 0, 8'h00);
      vt[5]  = mk(0, 0, 8'h00, 4'hF, 4'h0, 1, 4'hF, 0, 8'h00);
      vt[6]  = mk(1, 2, 8'hB0, 4'h0, 4'h4, 1, 4'hF, 0, 8'hB0);
      vt[7]  = mk(1, 2, 8'hB1, 4'h0, 4'h4, 1, 4'hF, 0, 8'hB1);
      vt[8]  = mk(1, 2, 8'hB2, 4'h0, 4'h0, 0, 4'hB, 0, 8'h00);
      vt[9]  = mk(1, 2, 8'hB3, 4'h0, 4'h0, 0, 4'hB, 0, 8'h00);
      vt[10] = mk(0, 0, 8'h00, 4'h4, 4'h4, 1, 4'hF, 0, 8'hB2);
      vt[11] = mk(0, 0, 8'h00, 4'h0, 4'h0, 1, 4'hB, 0, 8'h00);
      vt[12] = mk(0, 0, 8'h00, 4'h4, 4'h0, 1, 4'hF, 0, 8'h00);
      vt[13] = mk(0, 0, 8'h00, 4'h4, 4'h0, 1, 4'hF, 0, 8'h00);
      vt[14] = mk(1, 1, 8'hC0, 4'h0, 4'h2, 1, 4'hF, 0, 8'hC0);
      vt[15] = mk(0, 0, 8'h00, 4'h2, 4'h0, 1, 4'hF, 0, 8'h00);
      vt[16] = mk(1, 1, 8'hC1, 4'h0, 4'h2, 1, 4'hF, 0, 8'hC1);
      vt[17] = mk(1, 1, 8'hC2, 4'h0, 4'h2, 1, 4'hF, 0, 8'hC2);
      vt[18] = mk(1, 1, 8'hC3, 4'h0, 4'h0, 0, 4'hD, 0, 8'h00);
      vt[19] = mk(0, 0, 8'h00, 4'h2, 4'h2, 1, 4'hF, 0, 8'hC3);
      vt[20] = mk(0, 0, 8'h00, 4'h2, 4'h0, 1, 4'hF, 0, 8'h00);
      vt[21] = mk(0, 0, 8'h00, 4'h2, 4'h0, 1, 4'hF, 0, 8'h00);
      vt[22] = mk(0, 0, 8'h00, 4'h1, 4'h0, 1, 4'hF, 1, 8'h00);
      vt[23] = mk(0, 0, 8'h00, 4'h0, 4'h0, 1, 4'hF, 1, 8'h00);

      rst = 1'b0;
      drive0(0, 0, 8'h00, 4'h0);
      bus1.in_vld = 1'b0; bus1.in_tag = '0; bus1.in_data = '0; bus1.credit_ret = '0;

      // T1: reset held two cycles, then released.
      repeat (2) tick();
      rst = 1'b1;
      tick();
      chk("t1 push", 32'(bus0.push), 32'h0);
      chk("t1 in_rdy", 32'(bus0.in_rdy), 32'h1);
      chk("t1 has_credits", 32'(has0), 32'hF);
      chk("t1 cr_err", 32'(cr_err0), 32'h0);
      chk("t1 tag_err", 32'(tag_err0), 32'h0);
      chk("t1 stall_cnt", 32'(stall0), 32'h0);
      chk("t1 has_credits nf3", 32'(has1), 32'h7);

      // T2-T5: vector table.
      for (int k = 0; k < NV; k++) begin
         drive0(vt[k].vld, vt[k].tag, vt[k].data, vt[k].ret);
         tick();
         chk($sformatf("r%0d push", k), 32'(bus0.push), 32'(vt[k].e_push));
         chk($sformatf("r%0d in_rdy", k), 32'(bus0.in_rdy), 32'(vt[k].e_rdy));
         chk($sformatf("r%0d has_credits", k), 32'(has0), 32'(vt[k].e_has));
         chk($sformatf("r%0d cr_err", k), 32'(cr_err0), 32'(vt[k].e_cr));
         for (int c = 0; c < NF; c++) begin
            if (vt[k].e_push[c])
               chk($sformatf("r%0d data ch%0d", k, c), 32'(bus0.flat_data_out[c*W +: W]),
                   32'(vt[k].e_data));
         end
      end
      drive0(0, 0, 8'h00, 4'h0);
      chk("table stall_cnt", 32'(stall0), STALL_EN ? 32'd3 : 32'd0);

      // T5b: out-of-range tag on the 3-channel build is dropped.
      bus1.in_vld = 1'b1; bus1.in_tag = 2'd3; bus1.in_data = 8'h5A;
      tick();
      chk("t5 tag_err", 32'(tag_err1), 32'h1);
      chk("t5 bad tag push", 32'(bus1.push), 32'h0);
      chk("t5 bad tag in_rdy", 32'(bus1.in_rdy), 32'h1);
      chk("t5 other tag_err", 32'(tag_err0), 32'h0);
      bus1.in_tag = 2'd0; bus1.in_data = 8'h66;
      tick();
      chk("t5 good push", 32'(bus1.push), 32'h1);
      chk("t5 good data", 32'(bus1.flat_data_out[7:0]), 32'h66);
      chk("t5 tag_err sticky", 32'(tag_err1), 32'h1);
      bus1.in_vld = 1'b0;
      tick();
      chk("t5 idle push", 32'(bus1.push), 32'h0);

      // T6: stall channel 3, then reset mid-stall.
      drive0(1, 3, 8'hD0, 4'h0); tick();
      chk("t6 push d0", 32'(bus0.push), 32'h8);
      drive0(1, 3, 8'hD1, 4'h0); tick();
      chk("t6 push d1", 32'(bus0.push), 32'h8);
      drive0(1, 3, 8'hD2, 4'h0); tick();
      chk("t6 blocked push", 32'(bus0.push), 32'h0);
      chk("t6 blocked in_rdy", 32'(bus0.in_rdy), 32'h0);
      drive0(0, 0, 8'h00, 4'h0);
      repeat (3) tick();
      chk("t6 still blocked", 32'(bus0.push), 32'h0);
      chk("t6 stall_cnt", 32'(stall0), STALL_EN ? 32'd6 : 32'd0);
      rst = 1'b0;
      tick();
      chk("t6 rst push", 32'(bus0.push), 32'h0);
      chk("t6 rst in_rdy", 32'(bus0.in_rdy), 32'h1);
      chk("t6 rst has_credits", 32'(has0), 32'hF);
      chk("t6 rst cr_err", 32'(cr_err0), 32'h0);
      chk("t6 rst stall_cnt", 32'(stall0), 32'h0);
      chk("t6 rst tag_err nf3", 32'(tag_err1), 32'h0);
      rst = 1'b1;
      tick();
      chk("t6 post push", 32'(bus0.push), 32'h0);
      chk("t6 post has_credits", 32'(has0), 32'hF);
      // Credits restored to two: two pushes, then the third word blocks.
      drive0(1, 3, 8'hE0, 4'h0); tick();
      chk("t6 e0 push", 32'(bus0.push), 32'h8);
      chk("t6 e0 data", 32'(bus0.flat_data_out[3*W +: W]), 32'hE0);
      drive0(1, 3, 8'hE1, 4'h0); tick();
      chk("t6 e1 push", 32'(bus0.push), 32'h8);
      drive0(1, 3, 8'hE2, 4'h0); tick();
      chk("t6 e2 push", 32'(bus0.push), 32'h0);
      chk("t6 e2 in_rdy", 32'(bus0.in_rdy), 32'h0);
      chk("t6 e2 has_credits", 32'(has0), 32'h7);
      drive0(0, 0, 8'h00, 4'h0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
